// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request channel used by if_fetch_unit.
// The fetch unit is the master: it raises imem_req with a stable imem_addr
// and the memory answers with a one-cycle imem_ack carrying imem_rdata.
interface if_fetch_unit_if #(
    parameter int len_addr = 32,
    parameter int len_data = 32
);
    logic                imem_req;
    logic [len_addr-1:0] imem_addr;
    logic                imem_ack;
    logic [len_data-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF-stage fetch controller of a 5-stage MIPS pipeline.
// Issues one req/ack transaction per instruction to a variable-latency
// instruction memory, drives the PC write-enable, absorbs hazard stalls and
// branch flushes, and owns the IF/ID latch.
// Optional feature macro: FETCH_PERF_CNT_EN adds a saturating 32-bit
// fetch_wait_cycles counter (cycles spent waiting on the memory).
module if_fetch_unit #(
    parameter int len_addr = 32,
    parameter int len_data = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [len_addr-1:0] pc_in,
    output logic                pc_write,
    input  logic                stall,
    input  logic                flush,
    if_fetch_unit_if.master     imem,
    output logic [len_data-1:0] if_id_instr,
    output logic [len_addr-1:0] if_id_pc_next,
    output logic                if_id_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         fetch_wait_cycles
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Sequential PC increment; the add wraps naturally modulo 2^len_addr.
    localparam logic [len_addr-1:0] ADDR_STEP = {{(len_addr-3){1'b0}}, 3'b100};

    logic [1:0]          state_q,   state_d;
    logic                req_q,     req_d;
    logic [len_addr-1:0] addr_q,    addr_d;
    logic [len_data-1:0] hold_q,    hold_d;
    logic [len_data-1:0] instr_q,   instr_d;
    logic [len_addr-1:0] pc_next_q, pc_next_d;
    logic                valid_q,   valid_d;

    logic                ack_s;
    logic [len_data-1:0] rdata_s;
    logic                load_s;

    assign ack_s   = imem.imem_ack;
    assign rdata_s = imem.imem_rdata;

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc_next  = pc_next_q;
    assign if_id_valid    = valid_q;

    // A fetched instruction is available to IF/ID: acked in WAIT, or parked in HOLD.
    assign load_s = ((state_q == ST_WAIT) && ack_s) || (state_q == ST_HOLD);

    // PC advances on a flush (branch target) or whenever IF/ID accepts a new instruction.
    assign pc_write = flush
                    | ((state_q == ST_WAIT) & ack_s & ~stall)
                    | ((state_q == ST_HOLD) & ~stall);

    // Fetch FSM: request issue, ack wait, stall parking and flush draining.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (!flush) begin
                    addr_d  = pc_in;
                    req_d   = 1'b1;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (ack_s) begin
                    req_d = 1'b0;
                    if (flush) begin
                        state_d = ST_IDLE;
                    end else if (stall) begin
                        hold_d  = rdata_s;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (flush) begin
                    // The memory cannot be aborted: keep requesting and drop the answer.
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                if (flush || !stall) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // IF/ID latch update: flush > stall > load > bubble.
    always_comb begin
        instr_d   = instr_q;
        pc_next_d = pc_next_q;
        valid_d   = valid_q;
        if (flush) begin
            instr_d = '0;
            valid_d = 1'b0;
        end else if (stall) begin
            instr_d   = instr_q;
            pc_next_d = pc_next_q;
            valid_d   = valid_q;
        end else if (load_s) begin
            instr_d   = (state_q == ST_HOLD) ? hold_q : rdata_s;
            pc_next_d = addr_q + ADDR_STEP;
            valid_d   = 1'b1;
        end else begin
            instr_d = '0;
            valid_d = 1'b0;
        end
    end

    // State and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            addr_q    <= '0;
            hold_q    <= '0;
            instr_q   <= '0;
            pc_next_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            hold_q    <= hold_d;
            instr_q   <= instr_d;
            pc_next_q <= pc_next_d;
            valid_q   <= valid_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] wait_cnt_q, wait_cnt_d;

    assign fetch_wait_cycles = wait_cnt_q;

    // Count cycles spent waiting on memory (WAIT or DRAIN), saturating at all-ones.
    always_comb begin
        if (((state_q == ST_WAIT) || (state_q == ST_DRAIN)) && (wait_cnt_q != 32'hFFFF_FFFF)) begin
            wait_cnt_d = wait_cnt_q + 32'd1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // Performance counter register; flush does not clear it.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= 32'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

endmodule
